// File: rtl/serial_cpu_8bit.sv
// Multi-cycle CPU: 16-bit instructions fetched as two bytes over an 8-bit bus,
// eight 16-bit registers, shared instruction/data byte memory.
module serial_cpu_8bit #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 10,
  parameter int DEFAULT_PC_ADDR = 250
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  CPU_WAIT,
  input  logic [DATA_WIDTH-1:0] i_datain,
  input  logic [DATA_WIDTH-1:0] d_datain,
  output logic                  is_i_addr,
  output logic [1:0]            nxt,
  output logic [ADDR_WIDTH-1:0] i_addr,
  output logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_we,
  output logic [DATA_WIDTH-1:0] d_dataout
);

  localparam int PW = ADDR_WIDTH - 1;
  localparam logic [PW-1:0] DEF_PC = PW'(DEFAULT_PC_ADDR);
  localparam logic [PW-1:0] PC_ONE = PW'(1);

  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_SET   = 5'b10011;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_LO = 3'd1,
    S_FETCH_HI = 3'd2,
    S_EXEC     = 3'd3,
    S_MEM_LO   = 3'd4,
    S_MEM_HI   = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [15:0]     gr_q [8];
  logic [15:0]     gr_d [8];
  logic            z_q, z_d;
  logic [1:0]      nxt_q, nxt_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;

  logic            advance_s;
  logic [4:0]      op_s;
  logic [2:0]      rd_s, r1_s, r2_s;
  logic [7:0]      imm8_s;
  logic [3:0]      off4_s;
  logic            is_end_s;
  logic [PW-1:0]   ea_s, br_tgt_s;
  logic [15:0]     alu_res_s;
  logic            alu_wr_s, alu_zupd_s, br_take_s;

  assign advance_s = enable & ~CPU_WAIT;
  assign op_s      = ir_q[15:11];
  assign rd_s      = ir_q[10:8];
  assign r1_s      = ir_q[6:4];
  assign r2_s      = ir_q[2:0];
  assign imm8_s    = ir_q[7:0];
  assign off4_s    = ir_q[3:0];
  assign is_end_s  = (ir_q == 16'h0000);
  // gr_q[0] is never written, so indexing it directly reads zero.
  assign ea_s      = gr_q[r1_s][PW-1:0] + {{(PW-4){1'b0}}, off4_s};
  assign br_tgt_s  = gr_q[rd_s][PW-1:0] + {{(PW-8){1'b0}}, imm8_s};

  // ALU result, writeback/flag enables and branch decision for the current IR.
  always_comb begin
    alu_res_s  = 16'h0000;
    alu_wr_s   = 1'b0;
    alu_zupd_s = 1'b0;
    br_take_s  = 1'b0;
    case (op_s)
      OP_ADD:  begin alu_res_s = gr_q[r1_s] + gr_q[r2_s]; alu_wr_s = 1'b1; alu_zupd_s = 1'b1; end
      OP_SUB:  begin alu_res_s = gr_q[r1_s] - gr_q[r2_s]; alu_wr_s = 1'b1; alu_zupd_s = 1'b1; end
      OP_AND:  begin alu_res_s = gr_q[r1_s] & gr_q[r2_s]; alu_wr_s = 1'b1; alu_zupd_s = 1'b1; end
      OP_OR:   begin alu_res_s = gr_q[r1_s] | gr_q[r2_s]; alu_wr_s = 1'b1; alu_zupd_s = 1'b1; end
      OP_XOR:  begin alu_res_s = gr_q[r1_s] ^ gr_q[r2_s]; alu_wr_s = 1'b1; alu_zupd_s = 1'b1; end
      OP_CMP:  begin alu_res_s = gr_q[r1_s] - gr_q[r2_s]; alu_zupd_s = 1'b1; end
      OP_ADDI: begin alu_res_s = gr_q[rd_s] + {8'h00, imm8_s}; alu_wr_s = 1'b1; alu_zupd_s = 1'b1; end
      OP_SUBI: begin alu_res_s = gr_q[rd_s] - {8'h00, imm8_s}; alu_wr_s = 1'b1; alu_zupd_s = 1'b1; end
      OP_SET:  begin alu_res_s = {8'h00, imm8_s}; alu_wr_s = 1'b1; end
      OP_JMPR: br_take_s = 1'b1;
      OP_BZ:   br_take_s = z_q;
      OP_BNZ:  br_take_s = ~z_q;
      default: alu_res_s = 16'h0000;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a stalled or disabled core holds its state.
  always_comb begin
    state_d = state_q;
    if (advance_s) begin
      case (state_q)
        S_IDLE:     state_d = start ? S_FETCH_LO : S_IDLE;
        S_FETCH_LO: state_d = S_FETCH_HI;
        S_FETCH_HI: state_d = S_EXEC;
        S_EXEC: begin
          if (is_end_s)                                   state_d = S_IDLE;
          else if (op_s == OP_HALT)                       state_d = S_DONE;
          else if (op_s == OP_LOAD || op_s == OP_STORE)   state_d = S_MEM_LO;
          else                                            state_d = S_FETCH_LO;
        end
        S_MEM_LO:   state_d = S_MEM_HI;
        S_MEM_HI:   state_d = S_FETCH_LO;
        S_DONE:     state_d = start ? S_FETCH_LO : S_DONE;
        default:    state_d = S_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Datapath next values: IR assembly, PC, register file, Z, status and load byte.
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    gr_d  = gr_q;
    z_d   = z_q;
    nxt_d = nxt_q;
    mdr_d = mdr_q;
    if (advance_s) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) nxt_d = 2'b00;
          else       nxt_d = nxt_q;
        end
        S_FETCH_LO: ir_d[7:0] = i_datain;
        S_FETCH_HI: begin
          ir_d[15:8] = i_datain;
          pc_d       = pc_q + PC_ONE;
        end
        S_EXEC: begin
          if (is_end_s) begin
            pc_d  = DEF_PC;
            nxt_d = 2'b10;
          end else if (op_s == OP_HALT) begin
            pc_d  = DEF_PC;
            nxt_d = 2'b01;
          end else if (br_take_s) begin
            pc_d = br_tgt_s;
          end else begin
            if (alu_wr_s && rd_s != 3'd0) gr_d[rd_s] = alu_res_s;
            else                          gr_d[rd_s] = gr_q[rd_s];
            if (alu_zupd_s) z_d = (alu_res_s == 16'h0000);
            else            z_d = z_q;
          end
        end
        S_MEM_LO: begin
          if (op_s == OP_LOAD) mdr_d = d_datain;
          else                 mdr_d = mdr_q;
        end
        S_MEM_HI: begin
          if (op_s == OP_LOAD && rd_s != 3'd0) gr_d[rd_s] = {d_datain, mdr_q};
          else                                 gr_d[rd_s] = gr_q[rd_s];
        end
        default: pc_d = pc_q;
      endcase
    end else begin
      pc_d = pc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc_q  <= {PW{1'b0}};
      ir_q  <= 16'h0000;
      z_q   <= 1'b0;
      nxt_q <= 2'b00;
      mdr_q <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < 8; i++) gr_q[i] <= 16'h0000;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      z_q   <= z_d;
      nxt_q <= nxt_d;
      mdr_q <= mdr_d;
      gr_q  <= gr_d;
    end
  end

  // Bus outputs decoded from state; only the write strobe reacts to a stall.
  always_comb begin
    is_i_addr = 1'b1;
    i_addr    = {pc_q, 1'b0};
    d_addr    = {ea_s, 1'b0};
    d_we      = 1'b0;
    d_dataout = {DATA_WIDTH{1'b0}};
    nxt       = nxt_q;
    case (state_q)
      S_FETCH_HI: i_addr = {pc_q, 1'b1};
      S_MEM_LO: begin
        is_i_addr = 1'b0;
        if (op_s == OP_STORE) begin
          d_we      = advance_s;
          d_dataout = gr_q[rd_s][7:0];
        end else begin
          d_we      = 1'b0;
          d_dataout = {DATA_WIDTH{1'b0}};
        end
      end
      S_MEM_HI: begin
        is_i_addr = 1'b0;
        d_addr    = {ea_s, 1'b1};
        if (op_s == OP_STORE) begin
          d_we      = advance_s;
          d_dataout = gr_q[rd_s][15:8];
        end else begin
          d_we      = 1'b0;
          d_dataout = {DATA_WIDTH{1'b0}};
        end
      end
      default: is_i_addr = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_serial_cpu_8bit.sv
// Directed bench for serial_cpu_8bit with a behavioural 1024x8 shared memory.
module tb_serial_cpu_8bit;

  logic       clk, rst, enable, start, cpu_wait;
  logic [7:0] i_datain, d_datain, d_dataout;
  logic       is_i_addr, d_we;
  logic [1:0] nxt;
  logic [9:0] i_addr, d_addr;

  logic [7:0] mem [1024];
  logic       ld_en;
  logic [9:0] ld_addr;
  logic [7:0] ld_data;

  int n_checks = 0;
  int n_fail   = 0;
  int we_seen;

  serial_cpu_8bit #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .DEFAULT_PC_ADDR(250)) dut (
    .clk(clk), .rst_n(rst), .enable(enable), .start(start), .CPU_WAIT(cpu_wait),
    .i_datain(i_datain), .d_datain(d_datain), .is_i_addr(is_i_addr), .nxt(nxt),
    .i_addr(i_addr), .d_addr(d_addr), .d_we(d_we), .d_dataout(d_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign i_datain = mem[i_addr];
  assign d_datain = mem[d_addr];

  // Memory write port: core stores, otherwise bench program loading.
  always @(posedge clk) begin
    if (d_we)       mem[d_addr]  <= d_dataout;
    else if (ld_en) mem[ld_addr] <= ld_data;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic put_word(input int w, input logic [15:0] val);
    ld_en   = 1'b1;
    ld_addr = 10'(2 * w);
    ld_data = val[7:0];
    @(posedge clk); #1;
    ld_addr = 10'(2 * w + 1);
    ld_data = val[15:8];
    @(posedge clk); #1;
    ld_en   = 1'b0;
  endtask

  function automatic logic [15:0] get_word(input int w);
    return {mem[2 * w + 1], mem[2 * w]};
  endfunction

  // Leaves the bench on the negedge just after the start-accept edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_nxt(input int max_cyc);
    int n = 0;
    while (nxt == 2'b00 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("nxt_timeout", 16'(nxt != 2'b00), 16'h0001);
  endtask

  task automatic wait_mem(input int max_cyc);
    int n = 0;
    while (is_i_addr == 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("mem_phase", 16'(is_i_addr), 16'h0000);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_is_i"}, 16'(is_i_addr), 16'h0001);
    check_eq({tag, "_i_addr"}, 16'(i_addr), 16'h0000);
    check_eq({tag, "_d_addr"}, 16'(d_addr), 16'h0000);
    check_eq({tag, "_d_we"}, 16'(d_we), 16'h0000);
    check_eq({tag, "_d_out"}, 16'(d_dataout), 16'h0000);
    check_eq({tag, "_nxt"}, 16'(nxt), 16'h0000);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; start = 1'b0; cpu_wait = 1'b0;
    ld_en = 1'b0; ld_addr = 10'd0; ld_data = 8'h00;
    #1 rst = 1'b1;

    put_word(0, 16'hC8FA);    // JMPR gr0,0xFA
    put_word(1, 16'h3C00);
    put_word(4, 16'hFFFF);
    put_word(250, 16'h9B04);  // SET gr3,4
    put_word(251, 16'h9900);  // SET gr1,0
    put_word(252, 16'h4113);  // ADD gr1,gr1,gr3
    put_word(253, 16'h5B01);  // SUBI gr3,1
    put_word(254, 16'hD8FC);  // BNZ gr0,0xFC
    put_word(255, 16'h1902);  // STORE gr1,gr0,2
    put_word(256, 16'h0000);  // END
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");

    // Jump from word 0 to word 250, then the summing loop.
    pulse_start();
    check_eq("fetch_lo0", 16'(i_addr), 16'h0000);
    @(negedge clk);
    check_eq("fetch_hi0", 16'(i_addr), 16'h0001);
    @(negedge clk);
    @(negedge clk);
    check_eq("jmp_target", 16'(i_addr), 16'd500);
    wait_nxt(400);
    check_eq("end_nxt", 16'(nxt), 16'h0002);
    check_eq("loop_sum", get_word(2), 16'h000A);
    check_eq("end_pc", 16'(i_addr), 16'd500);

    // LOAD / ADD / STORE / HALT.
    put_word(250, 16'h1201);  // LOAD gr2,gr0,1
    put_word(251, 16'h4112);  // ADD gr1,gr1,gr2
    put_word(252, 16'h1903);  // STORE gr1,gr0,3
    put_word(253, 16'h0800);  // HALT
    pulse_start();
    check_eq("nxt_clear", 16'(nxt), 16'h0000);
    wait_nxt(400);
    check_eq("halt_nxt", 16'(nxt), 16'h0001);
    check_eq("ldst_word3", get_word(3), 16'h3C0A);
    check_eq("ldst_word1", get_word(1), 16'h3C00);

    // Stall in the middle of a STORE.
    put_word(250, 16'h1905);  // STORE gr1,gr0,5
    put_word(251, 16'h0800);  // HALT
    pulse_start();
    wait_mem(50);
    check_eq("store_we", 16'(d_we), 16'h0001);
    cpu_wait = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (d_we) we_seen++;
      @(negedge clk);
    end
    if (d_we) we_seen++;
    check_eq("stall_we", 16'(we_seen), 16'h0000);
    check_eq("stall_addr", 16'(d_addr), 16'd10);
    cpu_wait = 1'b0;
    wait_nxt(400);
    check_eq("stall_nxt", 16'(nxt), 16'h0001);
    check_eq("stall_word5", get_word(5), 16'h3C0A);

    // gr0 stays zero.
    put_word(250, 16'h9805);  // SET gr0,5
    put_word(251, 16'h1804);  // STORE gr0,gr0,4
    put_word(252, 16'h0800);  // HALT
    pulse_start();
    wait_nxt(400);
    check_eq("gr0_nxt", 16'(nxt), 16'h0001);
    check_eq("gr0_word4", get_word(4), 16'h0000);

    // Reset during the data phase of a STORE.
    put_word(250, 16'h9C21);  // SET gr4,0x21
    put_word(251, 16'h1C40);  // STORE gr4,gr4,0
    put_word(252, 16'h0800);  // HALT
    pulse_start();
    wait_mem(50);
    check_eq("pre_rst_d_addr", 16'(d_addr), 16'h0042);
    check_eq("pre_rst_d_out", 16'(d_dataout), 16'h0021);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    check_eq("restart_fetch", 16'(i_addr), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_eq("restart_jmp", 16'(i_addr), 16'd500);
    wait_nxt(400);
    check_eq("restart_nxt", 16'(nxt), 16'h0001);
    check_eq("restart_store", get_word(33), 16'h0021);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_cpu_8bit.md
# serial_cpu_8bit

Multi-cycle 16-bit-instruction CPU core with an 8-bit memory bus. It fetches each instruction as two bytes and executes a reduced load/store ISA on eight 16-bit registers. It shares one external 1024x8 byte memory (I_MEMORY_8BIT) for instructions and data via the `is_i_addr` select. The `nxt` outputs report "program halted" or "instruction window exhausted", so the host can reload code and restart the core with `start`.

## Interface
Reset is asynchronous and active-high. The codebase keeps the port name `rst_n`.

Parameters:
- DATA_WIDTH, 8, memory bus width.
- ADDR_WIDTH, 10, byte address width.
- DEFAULT_PC_ADDR, 250, word address where execution restarts after END or HALT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-high
- enable  in  1  core enable; low freezes all state and ignores start
- start  in  1  level-sampled run request
- CPU_WAIT  in  1  stall; high freezes all state, forces d_we=0
- i_datain  in  8  instruction byte from memory
- d_datain  in  8  data byte from memory
- is_i_addr  out  1  1 = memory addressed by i_addr, 0 = by d_addr
- nxt  out  2  [0] halted (HALT executed); [1] window exhausted (END fetched)
- i_addr  out  10  instruction byte address {PC[8:0], byte}
- d_addr  out  10  data byte address {EA[8:0], byte}
- d_we  out  1  data byte write strobe
- d_dataout  out  8  data byte to memory

## Operation
- Registers gr0..gr7 are 16-bit; gr0 reads 0 and writes to it are ignored. PC is a 9-bit word address. Z flag is 1 bit.
- Memory is little-endian: word w occupies byte 2w (low) and byte 2w+1 (high).
- Companion memory contract: read is combinational, dataout=RAM[addr]; write on the clk edge when d_we=1. Memory contents are not affected by reset.
- Instruction fields: [15:11] op, [10:8] rd/rs, [6:4] r1, [2:0] r2, [7:0] imm8, [3:0] off4.
- Opcodes and semantics:
  - NOP 00000: no operation. The exact word 0x0000 is END instead.
  - HALT 00001.
  - LOAD 00010: rd=M[gr[r1]+off4].
  - STORE 00011: M[gr[r1]+off4]=gr[rd].
  - ADD 01000 / SUB 01010 / AND 01101 / OR 01110 / XOR 01111: rd=r1 op r2.
  - CMP 01100: r1-r2, flags only, no writeback.
  - ADDI 01001 / SUBI 01011: rd=rd±zext(imm8).
  - SET 10011: rd=zext(imm8).
  - JMPR 11001: PC=gr[rd]+imm8.
  - BZ 11010: PC=gr[rd]+imm8 if Z=1.
  - BNZ 11011: PC=gr[rd]+imm8 if Z=0.
  - Any other opcode executes as NOP.
- Arithmetic wraps mod 2^16. Z=(result==0), updated only by ALU ops (ADD, SUB, AND, OR, XOR, CMP, ADDI, SUBI). Effective address and branch target are taken mod 512 words.
- States:
  - IDLE: is_i_addr=1. When start=1 → FETCH_LO.
  - FETCH_LO: i_addr={PC,0}; IR[7:0]←i_datain → FETCH_HI.
  - FETCH_HI: i_addr={PC,1}; IR[15:8]←i_datain; PC←PC+1 → EXEC.
  - EXEC, by instruction:
    - ALU/SET: write back, → FETCH_LO.
    - Branch: load PC if taken, → FETCH_LO.
    - LOAD/STORE: → MEM_LO.
    - HALT: → DONE.
    - END: PC←DEFAULT_PC_ADDR, → IDLE with nxt[1]=1.
  - MEM_LO / MEM_HI: is_i_addr=0; d_addr={EA,0} / {EA,1}.
    - STORE: d_dataout=gr[rd] low byte / high byte; d_we=1 for that cycle.
    - LOAD: capture each byte; write rd at the end of MEM_HI.
    - MEM_HI → FETCH_LO.
  - DONE: nxt[0]=1; PC←DEFAULT_PC_ADDR. When start=1 → FETCH_LO.
- nxt[1] is held in IDLE until start; nxt[0] is held in DONE until start. Both clear on the start-accept edge.
- Registers and Z persist across END/restart. Only reset clears them.

## Timing
- Reset values: state=IDLE, PC=0, all registers 0, Z=0, nxt=00, is_i_addr=1, i_addr=d_addr=0, d_we=0, d_dataout=0.
- Outputs are combinational decodes of the current state and registers.
- start is sampled on the rising edge only in IDLE/DONE, with enable=1 and CPU_WAIT=0; it is ignored elsewhere.
- Latency: ALU/SET/branch/NOP 3 cycles; LOAD/STORE 5 cycles; HALT/END 3 cycles to nxt assertion.
- enable=0 or CPU_WAIT=1 holds state, PC, IR and registers. Outputs keep their values except d_we, which is forced to 0. Execution resumes with no lost or duplicated bytes.
- Asynchronous reset mid-instruction aborts it; a partially written STORE word is acceptable.
- The first start after reset executes from word 0.

## Test plan
- Reset, then start: word0=JMPR gr0,0xFA → first fetch after the jump at byte 500.
- At word 250, program SET gr3,4; SET gr1,0; ADD gr1,gr1,gr3; SUBI gr3,1; BNZ gr0,0xFC; STORE gr1,gr0,2; then 0x0000 → word2=0x000A, then nxt=10.
- With word1=0x3C00, overwrite 250.. with LOAD gr2,gr0,1; ADD gr1,gr1,gr2; STORE gr1,gr0,3; HALT, then start → word3=0x3C0A, word1 still 0x3C00, nxt=01.
- Assert CPU_WAIT for 5 cycles during a STORE → no d_we while stalled, same final memory contents.
- Write to gr0 (SET gr0,5), then STORE gr0,gr0,4 → word4=0x0000.
- Assert reset mid-program → all outputs return to their reset values immediately; the next start fetches from byte 0.
